// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu plus mthi/mtlo,
// owning the HI/LO registers and exposing Busy for D-stage hazard stalls.
`timescale 1ns/1ps
module mdu_e #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [2:0]  MDop,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               pend_we_q, pend_we_d;
   logic               busy_d;
   logic [31:0]        hi_d, lo_d;

   // Full-width result datapath, evaluated on the operands present at the Start edge
   logic               is_signed;
   logic [63:0]        mul_a, mul_b, product;
   logic               a_neg, b_neg;
   logic [31:0]        ua, ub, ub_safe, uq, ur;
   logic [31:0]        div_q, div_r;

   always_comb begin
      is_signed = (MDop == OP_MULT) || (MDop == OP_DIV);
      mul_a     = is_signed ? {{32{SrcA[31]}}, SrcA} : {32'd0, SrcA};
      mul_b     = is_signed ? {{32{SrcB[31]}}, SrcB} : {32'd0, SrcB};
      product   = mul_a * mul_b;

      // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN without trapping
      a_neg   = is_signed && SrcA[31];
      b_neg   = is_signed && SrcB[31];
      ua      = a_neg ? (~SrcA + 32'd1) : SrcA;
      ub      = b_neg ? (~SrcB + 32'd1) : SrcB;
      ub_safe = (ub == 32'd0) ? 32'd1 : ub;
      uq      = ua / ub_safe;
      ur      = ua % ub_safe;
      div_q   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
      div_r   = a_neg ? (~ur + 32'd1) : ur;
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;
      busy_d    = Busy;
      hi_d      = HI;
      lo_d      = LO;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               case (MDop)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_d = product[63:32];
                     pend_lo_d = product[31:0];
                     pend_we_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = div_r;
                     pend_lo_d = div_q;
                     pend_we_d = (SrcB != 32'd0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = S_BUSY;
                  end
                  OP_MTHI: hi_d = SrcA;
                  OP_MTLO: lo_d = SrcA;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               if (pend_we_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               pend_we_d = 1'b0;
               cnt_d     = '0;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and architectural registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_we_q <= 1'b0;
         Busy      <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
         Busy      <= busy_d;
         HI        <= hi_d;
         LO        <= lo_d;
      end
   end

endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
Multiply/divide unit in the E stage of the pipelined MIPS CPU, sitting beside the combinational ALU. It takes the same forwarded operands (SrcA, SrcB), runs multi-cycle mult/multu/div/divu operations and mthi/mtlo writes, and holds the HI/LO architectural registers. It exposes Busy so hazard logic can stall dependent mfhi/mflo/md instructions in D stage.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (>=1)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state at the rising edge where it is high
SrcA  input  32  operand A (rs, forwarded)
SrcB  input  32  operand B (rt, forwarded)
MDop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
Start  input  1  qualifies MDop for one cycle; E-stage instruction is a valid md op
Busy  output  1  operation in progress
HI  output  32  HI register (registered)
LO  output  32  LO register (registered)

Behaviour:
- Reset: HI=0, LO=0, Busy=0, counter=0, state IDLE, pending results discarded. Reset overrides Start in the same cycle; reset during BUSY aborts with no HI/LO write.
- FSM: IDLE, BUSY.
- IDLE, Start=1, MDop in 1..4: latch operands, compute result into hidden pending regs, load counter = MULT_CYCLES (1,2) or DIV_CYCLES (3,4), go BUSY. Busy=1 from the cycle after that edge.
- BUSY: counter decrements each edge; at the edge where counter==1, HI/LO <= pending, Busy <= 0, go IDLE. Busy high for exactly N cycles; new HI/LO visible the same cycle Busy reads 0.
- HI/LO never change while BUSY (no partial results visible).
- Start=1 while BUSY: ignored entirely (hazard unit guarantees stall; block must not corrupt state).
- IDLE, Start=1, MDop 5: HI <= SrcA at that edge, LO unchanged, Busy stays 0. MDop 6: LO <= SrcA, HI unchanged. Single-cycle.
- Start=1 with MDop 0 or 7: no effect. Start=0: MDop ignored.
- mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0]. multu: unsigned, same split.
- div: signed; LO = quotient truncated toward zero, HI = remainder with sign of dividend (SrcA). divu: unsigned.
- Divisor 0 (div or divu): Busy still asserted for DIV_CYCLES; at completion HI/LO keep previous values.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000 (no trap).
- Operands latched at Start edge; SrcA/SrcB changes during BUSY have no effect.
- Back-to-back: Start may be accepted in the first IDLE cycle after Busy falls.

Test Plan:
- Reset: drive reset=1 mid-div (cycle 4 of 10), SrcA=100, SrcB=7 -> next cycle Busy=0, HI=0, LO=0; no write later.
- mult: SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF, MDop=1, Start pulse -> Busy high exactly 5 cycles, HI/LO unchanged meanwhile, then HI=0x00000000, LO=0x00000001; repeat with multu -> HI=0xFFFFFFFE, LO=0x00000001.
- div signed: SrcA=0xFFFFFFF9 (-7), SrcB=2, MDop=3 -> Busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- Divide-by-zero and overflow: preload HI=0x1234, LO=0x5678 via mthi/mtlo, div by 0 -> Busy 10 cycles, HI/LO stay 0x1234/0x5678; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start while busy: start mult 3x4, on cycle 2 assert Start with MDop=5, SrcA=0xDEAD -> ignored; after 5 cycles HI=0, LO=12, HI never 0xDEAD.
- mthi/mtlo and back-to-back: mtlo SrcA=0xAAAA5555 -> LO updated next edge, Busy=0; immediately issue multu 0x10000x0x10000 in the cycle Busy falls after a prior op -> accepted, result HI=1, LO=0.
